// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder slice (two half adders
// plus a carry flop) between two requesters; results come back LSB-aligned.
module serial_add_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   // Handshake: a request is taken on any cycle where reqN_valid and
   // reqN_ready are both high; ready is only offered in IDLE, never under rst.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             id_q, id_d;
   logic             last_q, last_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_cout_q, rsp_cout_d;
   logic             grant0, grant1;
   logic             s1, c1, c2, sum_bit, carry_nx;

   always_comb begin
      grant0     = req0_valid & (~req1_valid | last_q);
      grant1     = req1_valid & (~req0_valid | ~last_q);
      req0_ready = (state_q == IDLE) & grant0 & ~rst;
      req1_ready = (state_q == IDLE) & grant1 & ~rst;

      s1       = a_q[0] ^ b_q[0];
      c1       = a_q[0] & b_q[0];
      sum_bit  = s1 ^ carry_q;
      c2       = s1 & carry_q;
      carry_nx = c1 | c2;

      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      carry_d    = carry_q;
      id_d       = id_q;
      last_d     = last_q;
      rsp_sum_d  = rsp_sum_q;
      rsp_cout_d = rsp_cout_q;
      rsp_id_d   = rsp_id_q;

      case (state_q)
         IDLE: begin
            if (req0_ready | req1_ready) begin
               a_d     = req1_ready ? req1_a : req0_a;
               b_d     = req1_ready ? req1_b : req0_b;
               carry_d = 1'b0;
               cnt_d   = '0;
               id_d    = req1_ready;
               last_d  = req1_ready;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
            carry_d = carry_nx;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Result registers stay put outside DONE until the next result.
               state_d    = DONE;
               rsp_sum_d  = {sum_bit, acc_q[WIDTH-1:1]};
               rsp_cout_d = carry_nx;
               rsp_id_d   = id_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         id_q       <= 1'b0;
         last_q     <= 1'b1;
         rsp_sum_q  <= '0;
         rsp_cout_q <= 1'b0;
         rsp_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         carry_q    <= carry_d;
         id_q       <= id_d;
         last_q     <= last_d;
         rsp_sum_q  <= rsp_sum_d;
         rsp_cout_q <= rsp_cout_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign rsp_valid = (state_q == DONE) & ~rst;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched: cycle-level arithmetic model with a result
// queue, directed scenarios with literal expectations, then random traffic.
module tb_serial_add_sched;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
   logic [W-1:0] rsp_sum;

   serial_add_sched #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .busy(busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard / model ----------------
   int  n_vec = 0, n_err = 0;
   bit  chk_en = 0;
   int  m_timer = 0;                 // cycles left until the block is idle again
   logic m_last = 1'b1;
   logic [W+1:0] exp_q[$];           // {id, cout, sum} per accepted operation
   logic [W+1:0] ent;
   logic [W-1:0] h_sum = '0;
   logic         h_cout = 1'b0, h_id = 1'b0;
   logic         e_r0, e_r1, e_v;
   int           viol = 0;

   int           acc_cyc[$];
   logic         acc_id[$];
   int           rsp_cyc[$];
   logic         rsp_id_l[$];
   logic [W-1:0] rsp_sum_l[$];
   logic         rsp_cout_l[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d expected=%0d cyc=%0d", name, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         e_r0 = !rst && m_timer == 0 && req0_valid && (!req1_valid || m_last);
         e_r1 = !rst && m_timer == 0 && req1_valid && (!req0_valid || !m_last);
         if (m_timer == 1 && exp_q.size() > 0) begin
            ent    = exp_q.pop_front();
            h_id   = ent[W+1];
            h_cout = ent[W];
            h_sum  = ent[W-1:0];
         end
         e_v = (m_timer == 1) && !rst;

         chk("req0_ready", req0_ready, e_r0);
         chk("req1_ready", req1_ready, e_r1);
         chk("busy", busy, m_timer > 0);
         chk("rsp_valid", rsp_valid, e_v);
         chk("rsp_sum", rsp_sum, h_sum);
         chk("rsp_cout", rsp_cout, h_cout);
         chk("rsp_id", rsp_id, h_id);

         if (busy && (req0_ready || req1_ready)) viol++;
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            acc_cyc.push_back(cyc);
            acc_id.push_back(req1_valid && req1_ready);
         end
         if (rsp_valid) begin
            rsp_cyc.push_back(cyc);
            rsp_id_l.push_back(rsp_id);
            rsp_sum_l.push_back(rsp_sum);
            rsp_cout_l.push_back(rsp_cout);
         end

         if (rst) begin
            m_timer = 0;
            m_last  = 1'b1;
            exp_q.delete();
            h_sum   = '0;
            h_cout  = 1'b0;
            h_id    = 1'b0;
         end else if (m_timer > 0) begin
            m_timer--;
         end else if (e_r0) begin
            exp_q.push_back({1'b0, {1'b0, req0_a} + {1'b0, req0_b}});
            m_last  = 1'b0;
            m_timer = W + 1;
         end else if (e_r1) begin
            exp_q.push_back({1'b1, {1'b0, req1_a} + {1'b0, req1_b}});
            m_last  = 1'b1;
            m_timer = W + 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input int n, input int budget);
      int k = 0;
      while (acc_cyc.size() < n && k < budget) begin
         step(1);
         k++;
      end
      chk("accept_wait", acc_cyc.size(), n);
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int k = 0;
      while (rsp_cyc.size() < n && k < budget) begin
         step(1);
         k++;
      end
      chk("rsp_wait", rsp_cyc.size(), n);
   endtask

   task automatic pulse_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; end
      else         begin req1_valid = 1; req1_a = a; req1_b = b; end
      step(1);
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic do_reset(input int n);
      rst = 1;
      step(n);
      rst = 0;
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int ab, rb;
      step(2);
      chk_en = 1;
      do_reset(1);
      chk("reset_sum", rsp_sum, 0);
      chk("reset_busy", busy, 0);

      // single add
      ab = acc_cyc.size(); rb = rsp_cyc.size();
      pulse_req(0, 3, 5);
      wait_rsp(rb + 1, 20);
      chk("single_sum", rsp_sum_l[rb], 8);
      chk("single_cout", rsp_cout_l[rb], 0);
      chk("single_id", rsp_id_l[rb], 0);
      chk("single_latency", rsp_cyc[rb] - acc_cyc[ab], W + 1);
      step(1);

      // carry chain from requester 1
      rb = rsp_cyc.size();
      pulse_req(1, 255, 1);
      wait_rsp(rb + 1, 20);
      step(1);
      pulse_req(1, 255, 255);
      wait_rsp(rb + 2, 20);
      chk("carry_sum0", rsp_sum_l[rb], 0);
      chk("carry_cout0", rsp_cout_l[rb], 1);
      chk("carry_id0", rsp_id_l[rb], 1);
      chk("carry_sum1", rsp_sum_l[rb+1], 254);
      chk("carry_cout1", rsp_cout_l[rb+1], 1);
      step(1);

      // tie right after reset
      do_reset(2);
      ab = acc_cyc.size(); rb = rsp_cyc.size();
      req0_valid = 1; req0_a = 10;  req0_b = 20;
      req1_valid = 1; req1_a = 100; req1_b = 200;
      wait_acc(ab + 2, 40);
      req0_valid = 0; req1_valid = 0;
      wait_rsp(rb + 2, 40);
      chk("tie_id0", rsp_id_l[rb], 0);
      chk("tie_sum0", rsp_sum_l[rb], 30);
      chk("tie_cout0", rsp_cout_l[rb], 0);
      chk("tie_id1", rsp_id_l[rb+1], 1);
      chk("tie_sum1", rsp_sum_l[rb+1], 44);
      chk("tie_cout1", rsp_cout_l[rb+1], 1);
      chk("tie_spacing", acc_cyc[ab+1] - acc_cyc[ab], W + 2);
      step(1);

      // fairness over six operations
      ab = acc_cyc.size();
      req0_valid = 1; req1_valid = 1;
      wait_acc(ab + 6, 100);
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 6; i++) chk("fair_id", acc_id[ab+i], i % 2);
      step(W + 3);

      // operand change and competing request during RUN
      ab = acc_cyc.size(); rb = rsp_cyc.size();
      pulse_req(0, 7, 9);
      req0_a = 1; req0_b = 1;
      req1_valid = 1; req1_a = 50; req1_b = 60;
      wait_acc(ab + 2, 40);
      req1_valid = 0;
      wait_rsp(rb + 2, 40);
      chk("busy_change_sum", rsp_sum_l[rb], 16);
      chk("busy_change_id", rsp_id_l[rb], 0);
      chk("late_req1_id", acc_id[ab+1], 1);
      chk("late_req1_gap", acc_cyc[ab+1] - acc_cyc[ab], W + 2);
      chk("late_req1_sum", rsp_sum_l[rb+1], 110);
      step(1);

      // reset three cycles into RUN
      rb = rsp_cyc.size();
      pulse_req(0, 40, 2);
      step(2);
      do_reset(1);
      step(W + 4);
      chk("abort_no_rsp", rsp_cyc.size(), rb);
      chk("abort_sum", rsp_sum, 0);
      chk("abort_id", rsp_id, 0);
      chk("abort_cout", rsp_cout, 0);
      chk("abort_busy", busy, 0);
      ab = acc_cyc.size();
      req0_valid = 1; req0_a = W'($urandom); req0_b = W'($urandom);
      req1_valid = 1; req1_a = W'($urandom); req1_b = W'($urandom);
      wait_acc(ab + 1, 10);
      req0_valid = 0; req1_valid = 0;
      chk("abort_then_tie_id", acc_id[ab], 0);
      step(W + 3);

      // random traffic with occasional reset
      for (int i = 0; i < 800; i++) begin
         rst        = ($urandom_range(0, 47) == 0);
         req0_valid = ($urandom_range(0, 9) < 6);
         req1_valid = ($urandom_range(0, 9) < 6);
         req0_a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
         req0_b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
         req1_a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         req1_b = W'($urandom);
         step(1);
      end
      rst = 0; req0_valid = 0; req1_valid = 0;
      step(W + 4);

      chk("ready_while_busy", viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Round-robin scheduler that shares one bit-serial adder slice between two requesters. The slice is built from two half adders plus a carry flop. Each accepted request adds two WIDTH-bit operands LSB-first, one bit per clock. The block returns a WIDTH-bit sum, a carry-out and the requester ID. It sits beside the half-adder datapath and trades area for latency when several clients need addition.

## Interface
- WIDTH, default 8: operand and sum width; legal range 2..16.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_a, req0_b  input  WIDTH  requester 0 operands; sampled only on the accept cycle.
- req0_ready  output  1  requester 0 accepted this cycle (combinational).
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- rsp_valid  output  1  one-cycle pulse; result fields are valid.
- rsp_id  output  1  requester that owns the result.
- rsp_sum  output  WIDTH  (a + b) mod 2^WIDTH.
- rsp_cout  output  1  bit WIDTH of a + b.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- Arbitration happens in IDLE only:
  - If one valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - last_grant resets to 1, so requester 0 wins the first tie.
- reqN_ready = (state == IDLE) & granted(N) & !rst. At most one ready is high in a cycle.
- Accept = reqN_valid & reqN_ready. On accept:
  - Load shift registers A and B from the winner's operands.
  - Clear the carry flop and the bit counter.
  - Record the winner's ID and update last_grant.
  - Go to RUN.
- RUN, once per cycle:
  - x = A[0], y = B[0].
  - Half adder 1: s1 = x ^ y, c1 = x & y.
  - Half adder 2: sum bit = s1 ^ carry, c2 = s1 & carry.
  - Next carry = c1 | c2.
  - Shift A and B right by one. Shift the sum bit into the MSB of the sum register, so after WIDTH shifts it is LSB-aligned.
  - Increment the counter. When counter == WIDTH-1, go to DONE.
- DONE:
  - rsp_valid = 1 for exactly one cycle; rsp_cout = final carry; rsp_id = recorded ID.
  - Return to IDLE.
- There is no backpressure on the response; the consumer must take it on the pulse.
- While busy, both readys are low. Valid inputs and operand changes are ignored and do not disturb the operation in flight.
- Counter width is ceil(log2(WIDTH)); it never wraps inside one operation.

## Timing
- Accept at edge t means valid and ready are both high in the cycle before edge t.
- RUN occupies cycles t+1 .. t+WIDTH.
- rsp_valid is high in cycle t+WIDTH+1 (DONE).
- The next accept can happen in cycle t+WIDTH+2 at the earliest.
- Throughput is one operation per WIDTH+2 cycles.
- rsp_sum, rsp_cout and rsp_id are held stable outside DONE until the next result. They are meaningful only while rsp_valid is high.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0. Both readys are low while rst is high. last_grant=1, state=IDLE.
- rst asserted mid-operation: the operation is aborted and no rsp_valid is produced. All outputs take their reset values at the next edge. The requester must resubmit.
- rst and DONE in the same cycle: reset wins and no pulse is emitted.

## Test plan
- Single add, WIDTH=8: req0 presents a=3, b=5 for one accept.
  -> req0_ready high in that cycle; rsp_valid exactly 9 cycles after the accept edge, with sum=8, cout=0, id=0.
- Carry chain: req1 presents a=255, b=1.
  -> sum=0, cout=1, id=1. Also a=255, b=255 -> sum=254, cout=1.
- Tie after reset: both valids held high with req0 (10,20) and req1 (100,200).
  -> req0 served first (sum=30, cout=0, id=0); then req1 (sum=44, cout=1, id=1); accepts exactly 10 cycles apart.
- Fairness: both valids held high for 6 operations.
  -> ids alternate 0,1,0,1,0,1; no ready is high while busy.
- Operand change while busy: req0 accepted with (7,9); its operands are changed to (1,1) during RUN.
  -> result is 16. A req1 valid raised mid-run is accepted only after DONE.
- Reset mid-op: rst pulsed 3 cycles into RUN.
  -> no rsp_valid; all outputs zero; busy low. The next tie grants req0 first.
